// File: rtl/fifo_pkg.sv
// Shared definitions for the SyncFIFO read-side packer: FSM encoding and width helpers.
package fifo_pkg;

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int unsigned CNTW(input int unsigned pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_timer.sv
// Saturating idle counter; expired flags the last idle cycle before a partial beat is forced out.
module fifo_rd_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int unsigned   TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - ((TIMEOUT > 0) ? 1 : 0));

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= '0;
        end else if (inc && cnt != TMAX) begin
            cnt <= cnt + TW'(1);
        end
    end

    // Firing at TIMEOUT-1 makes the beat valid exactly TIMEOUT edges after the last pop.
    assign expired = (TIMEOUT > 0) && (cnt == TLAST);

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains a first-word-fall-through FIFO and packs PACK words per beat onto a valid/ready stream.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int unsigned BITWIDTH = 5,
    parameter int unsigned PACK     = 4,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     empty,
    output logic                     rEn,
    input  logic [BITWIDTH-1:0]      fifoData,
    input  logic                     flush,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [BITWIDTH*PACK-1:0] outData,
    output logic [CNTW(PACK)-1:0]    outCount
);

    localparam int unsigned IW = $clog2(PACK);
    localparam int unsigned CW = CNTW(PACK);

    state_t              state, state_nx;
    logic [IW-1:0]       idx;
    logic [BITWIDTH-1:0] lanes [PACK];
    logic [CW-1:0]       cnt, cnt_nx;
    logic                pop;
    logic                idx_last;
    logic                tmo;
    logic                tmr_clr;
    logic                tmr_inc;

    assign idx_last = (idx == IW'(PACK - 1));

    always_comb begin
        rEn      = 1'b0;
        state_nx = state;
        cnt_nx   = cnt;
        if (state == FILL) begin
            rEn = rst & ~empty;
        end
        pop = rEn & ~empty;
        case (state)
            FILL: begin
                if (pop && idx_last) begin
                    state_nx = SEND;
                    cnt_nx   = CW'(PACK);
                end else if (flush && (idx != '0 || pop)) begin
                    state_nx = SEND;
                    cnt_nx   = CW'(idx) + CW'(pop);
                end else if (tmo && idx != '0 && !pop) begin
                    state_nx = SEND;
                    cnt_nx   = CW'(idx);
                end
            end
            SEND: begin
                if (outReady) begin
                    state_nx = FILL;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx <= '0;
            cnt <= '0;
            for (int unsigned k = 0; k < PACK; k++) begin
                lanes[k] <= '0;
            end
        end else begin
            cnt <= cnt_nx;
            if (state == SEND) begin
                if (outReady) begin
                    idx <= '0;
                    for (int unsigned k = 0; k < PACK; k++) begin
                        lanes[k] <= '0;
                    end
                end
            end else if (pop) begin
                lanes[idx] <= fifoData;
                // idx holds on the final pop so it never wraps past PACK-1.
                if (state_nx == FILL) begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

    assign tmr_clr = pop | (state == SEND);
    assign tmr_inc = (state == FILL) & (idx != '0) & ~pop;

    fifo_rd_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (tmo)
    );

    always_comb begin
        outData = '0;
        for (int unsigned k = 0; k < PACK; k++) begin
            outData[k*BITWIDTH +: BITWIDTH] = lanes[k];
        end
    end

    assign outValid = (state == SEND);
    assign outCount = cnt;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-backed FIFO plus a word-list model of the packing rules.
module tb_fifo_rd_packer;

    localparam int BW = 5;
    localparam int P  = 4;
    localparam int TO = 15;
    localparam int CW = $clog2(P + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            empty;
    logic            rEn;
    logic [BW-1:0]   fifoData;
    logic            flush;
    logic            outValid;
    logic            outReady;
    logic [BW*P-1:0] outData;
    logic [CW-1:0]   outCount;

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] q[$];
    logic [BW-1:0] m_words[$];
    bit            m_send;
    int            m_idle;

    bit            exp_ren;
    bit            exp_valid;
    logic [CW-1:0] exp_cnt;
    logic [BW*P-1:0] exp_data;

    fifo_rd_packer #(
        .BITWIDTH (BW),
        .PACK     (P),
        .TIMEOUT  (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .empty    (empty),
        .rEn      (rEn),
        .fifoData (fifoData),
        .flush    (flush),
        .outValid (outValid),
        .outReady (outReady),
        .outData  (outData),
        .outCount (outCount)
    );

    always #5 clk = ~clk;

    function automatic logic [BW*P-1:0] packw();
        logic [BW*P-1:0] v;
        v = '0;
        for (int i = 0; i < m_words.size(); i++) begin
            v = v | ({{(BW*P-BW){1'b0}}, m_words[i]} << (i * BW));
        end
        return v;
    endfunction

    task automatic drive(input bit r, input bit stall, input bit fl, input bit rdy);
        rst      = r;
        flush    = fl;
        outReady = rdy;
        empty    = (q.size() == 0) || stall;
        fifoData = (q.size() != 0) ? q[0] : BW'($urandom);
        exp_ren   = r && !m_send && !empty;
        exp_valid = m_send;
        exp_cnt   = m_send ? CW'(m_words.size()) : '0;
        exp_data  = m_send ? packw() : '0;
        #1;
    endtask

    task automatic tick();
        bit popped;
        bit mpop;
        popped = rEn && !empty;
        if (!rst) begin
            m_send = 0;
            m_words.delete();
            m_idle = 0;
        end else if (m_send) begin
            if (outReady) begin
                m_send = 0;
                m_words.delete();
                m_idle = 0;
            end
        end else begin
            mpop = !empty;
            if (mpop) begin
                m_words.push_back(fifoData);
                m_idle = 0;
            end
            if (m_words.size() == P) begin
                m_send = 1;
            end else if (flush && m_words.size() > 0) begin
                m_send = 1;
            end else if (TO > 0 && m_words.size() > 0 && !mpop) begin
                m_idle++;
                if (m_idle == TO) m_send = 1;
            end
        end
        @(posedge clk);
        if (popped) void'(q.pop_front());
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || m_send || m_words.size() != 0) && n < 40) begin
            drive(1, 0, 1, 1);
            total++;
            if (rEn !== exp_ren || outValid !== exp_valid) begin
                bad++;
                $display("FAIL drain_ctl: rEn=%b outValid=%b want rEn=%b outValid=%b", rEn, outValid, exp_ren, exp_valid);
            end
            if (exp_valid) begin
                total++;
                if (outData !== exp_data || outCount !== exp_cnt) begin
                    bad++;
                    $display("FAIL drain_beat: data=%h cnt=%0d want data=%h cnt=%0d", outData, outCount, exp_data, exp_cnt);
                end
            end
            tick();
            n++;
        end
        total++;
        if (n >= 40) begin
            bad++;
            $display("FAIL drain_timeout: still busy after %0d cycles, want idle", n);
        end
    endtask

    task automatic test_reset();
        q = '{5'h01, 5'h02, 5'h03, 5'h04};
        drive(0, 0, 0, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1);
            total++;
            if (rEn !== 1'b0 || outValid !== 1'b0 || outData !== '0 || outCount !== '0) begin
                bad++;
                $display("FAIL reset_outputs: rEn=%b valid=%b data=%h cnt=%0d want all 0", rEn, outValid, outData, outCount);
            end
            tick();
        end
        total++;
        if (q.size() !== 4) begin
            bad++;
            $display("FAIL reset_no_pop: fifo depth %0d want 4", q.size());
        end
    endtask

    task automatic test_full_beat();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 1);
            total++;
            if (rEn !== 1'b1 || outValid !== 1'b0) begin
                bad++;
                $display("FAIL full_fill: cycle %0d rEn=%b valid=%b want 1/0", i, rEn, outValid);
            end
            tick();
        end
        drive(1, 0, 0, 1);
        total++;
        if (outValid !== 1'b1 || outData !== 20'h20C41 || outCount !== 3'd4 || rEn !== 1'b0) begin
            bad++;
            $display("FAIL full_beat: valid=%b data=%h cnt=%0d rEn=%b want 1 20c41 4 0", outValid, outData, outCount, rEn);
        end
        tick();
        drive(1, 0, 0, 1);
        total++;
        if (outValid !== 1'b0) begin
            bad++;
            $display("FAIL full_accept: valid=%b want 0", outValid);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [BW*P-1:0] held;
        for (int i = 0; i < 6; i++) q.push_back(BW'($urandom));
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 1);
            tick();
        end
        held = packw();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 0);
            total++;
            if (rEn !== 1'b0 || outValid !== 1'b1 || outData !== held || outCount !== 3'd4) begin
                bad++;
                $display("FAIL bp_hold: cycle %0d rEn=%b valid=%b data=%h cnt=%0d want 0 1 %h 4", i, rEn, outValid, outData, outCount, held);
            end
            tick();
        end
        drive(1, 0, 0, 1);
        tick();
        drive(1, 0, 0, 1);
        total++;
        if (rEn !== 1'b1 || outValid !== 1'b0) begin
            bad++;
            $display("FAIL bp_resume: rEn=%b valid=%b want 1/0", rEn, outValid);
        end
        tick();
        drain();
    endtask

    task automatic test_timeout();
        q.push_back(5'h1F);
        q.push_back(5'h0A);
        drive(1, 0, 0, 1);
        tick();
        drive(1, 0, 0, 1);
        tick();
        for (int n = 0; n <= TO; n++) begin
            drive(1, 0, 0, 1);
            total++;
            if (outValid !== (n == TO)) begin
                bad++;
                $display("FAIL timeout_edge: after %0d edges valid=%b want %b", n, outValid, (n == TO));
            end
            if (n < TO) tick();
        end
        total++;
        if (outData !== 20'h0015F || outCount !== 3'd2) begin
            bad++;
            $display("FAIL timeout_beat: data=%h cnt=%0d want 0015f 2", outData, outCount);
        end
        tick();
    endtask

    task automatic test_flush();
        q.push_back(5'h03);
        q.push_back(5'h05);
        q.push_back(5'h07);
        drive(1, 0, 0, 1);
        tick();
        drive(1, 0, 0, 1);
        tick();
        drive(1, 0, 1, 1);
        total++;
        if (rEn !== 1'b1) begin
            bad++;
            $display("FAIL flush_pop: rEn=%b want 1", rEn);
        end
        tick();
        drive(1, 0, 0, 1);
        total++;
        if (outValid !== 1'b1 || outCount !== 3'd3 || outData !== 20'h01CA3) begin
            bad++;
            $display("FAIL flush_beat: valid=%b data=%h cnt=%0d want 1 01ca3 3", outValid, outData, outCount);
        end
        tick();
    endtask

    task automatic test_reset_send();
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        for (int i = 0; i < 4; i++) q.push_back(BW'($urandom));
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0);
            tick();
        end
        drive(1, 0, 0, 0);
        total++;
        if (outValid !== 1'b1) begin
            bad++;
            $display("FAIL rsend_pending: valid=%b want 1", outValid);
        end
        tick();
        drive(0, 0, 0, 0);
        total++;
        if (rEn !== 1'b0) begin
            bad++;
            $display("FAIL rsend_ren: rEn=%b want 0", rEn);
        end
        tick();
        a = BW'($urandom);
        b = BW'($urandom);
        q.push_back(a);
        q.push_back(b);
        drive(1, 0, 0, 0);
        total++;
        if (outValid !== 1'b0 || outData !== '0) begin
            bad++;
            $display("FAIL rsend_cleared: valid=%b data=%h want 0 0", outValid, outData);
        end
        tick();
        drive(1, 0, 1, 0);
        tick();
        drive(1, 0, 0, 1);
        total++;
        if (outValid !== 1'b1 || outCount !== 3'd2 || outData !== {10'd0, b, a}) begin
            bad++;
            $display("FAIL rsend_next: valid=%b data=%h cnt=%0d want 1 %h 2", outValid, outData, outCount, {10'd0, b, a});
        end
        tick();
    endtask

    task automatic test_random();
        bit r, st, fl, rdy;
        int rate;
        for (int i = 0; i < 600; i++) begin
            rate = (i < 300) ? 2 : 20;
            if (q.size() < 6 && $urandom_range(0, rate - 1) == 0) q.push_back(BW'($urandom));
            r   = ($urandom_range(0, 99) != 0);
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            drive(r, st, fl, rdy);
            total++;
            if (rEn !== exp_ren || outValid !== exp_valid) begin
                bad++;
                $display("FAIL rand_ctl: i=%0d rEn=%b valid=%b want %b %b", i, rEn, outValid, exp_ren, exp_valid);
            end
            if (exp_valid) begin
                total++;
                if (outData !== exp_data || outCount !== exp_cnt) begin
                    bad++;
                    $display("FAIL rand_beat: i=%0d data=%h cnt=%0d want %h %0d", i, outData, outCount, exp_data, exp_cnt);
                end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        m_send = 0;
        m_idle = 0;
        test_reset();
        test_full_beat();
        test_backpressure();
        test_timeout();
        test_flush();
        test_reset_send();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
Read-side consumer for the SyncFIFO first-word-fall-through interface. It drains BITWIDTH-bit words using empty/rEn/fifoData and packs PACK consecutive words into one wide output beat. Each beat is presented on a valid/ready stream. A partial beat is emitted on an idle timeout or on an explicit flush. It sits between the FIFO's dOut side and a wide downstream consumer.

Parameters:
BITWIDTH, 5, width of one FIFO word; must equal the FIFO's BITWIDTH.
PACK, 4, words per output beat; PACK >= 2.
TIMEOUT, 15, idle cycles before a partial beat is emitted; 0 disables the timeout.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous reset, active-low; sampled on posedge clk.
empty  in  1  FIFO empty flag.
rEn  out  1  FIFO pop request; a pop occurs on a posedge where rEn=1 and empty=0.
fifoData  in  BITWIDTH  FIFO head word (FIFO dOut); valid whenever empty=0.
flush  in  1  force emission of the current partial beat.
outValid  out  1  output beat valid.
outReady  in  1  downstream accepts the beat when outValid=1 and outReady=1 at posedge.
outData  out  BITWIDTH*PACK  packed beat; lane k = bits [k*BITWIDTH +: BITWIDTH]; lane 0 holds the oldest word.
outCount  out  $clog2(PACK+1)  number of valid lanes in outData (1..PACK while outValid=1).

Behaviour:
- Reset (rst=0 at posedge): state=FILL, idx=0, all lanes=0, timer=0.
- After reset: outValid=0, outData=0, outCount=0.
- rEn is forced 0 combinationally while rst=0.
- A reset during SEND discards the held beat; no handshake completes.
- States are FILL and SEND. Registered state lives in idx, lanes, timer and state.
- FILL:
  - rEn = !empty (combinational); outValid=0.
  - pop = rEn & !empty. On pop, fifoData is written into lane idx and idx increments.
  - rEn never depends on fifoData. The FIFO's empty&rEn&wEn bypass path is never relied on, because rEn=0 whenever empty=1.
- FILL -> SEND on the posedge where the first of these holds, checked in priority order:
  - (a) pop and idx==PACK-1: full beat, outCount=PACK.
  - (b) flush=1 and (idx>0 or pop): outCount = idx + pop. A word popped in the same cycle is included.
  - (c) TIMEOUT>0, idx>0, no pop, and timer==TIMEOUT-1: outCount=idx.
  - flush with idx==0 and no pop is ignored.
- Timer behaviour:
  - Cleared on every pop and on entry to FILL.
  - Increments each FILL cycle with idx>0 and no pop.
  - Result: outValid rises exactly TIMEOUT posedges after the last pop.
- SEND:
  - outValid=1, rEn=0; outData and outCount are held stable until accepted.
  - Unused lanes read 0.
  - On outValid & outReady: return to FILL with idx=0, lanes=0, timer=0.
- Latency: the beat is valid the cycle after the posedge of its final pop.
- Throughput with the FIFO always non-empty and outReady=1: PACK words per PACK+1 cycles.
- Arithmetic and widths:
  - idx is $clog2(PACK) bits plus a terminal compare; it never wraps, because SEND is entered at PACK.
  - timer is $clog2(TIMEOUT+1) bits, saturating.
- flush and outReady are ignored outside the states where they apply. Behaviour is undefined if fifoData changes while empty=0 without a pop (the FIFO guarantees this does not happen).

Decomposition:
- Shared package fifo_pkg: state encoding (FILL, SEND) and a width helper, CNTW(PACK) = $clog2(PACK+1).
- One natural sub-module, fifo_rd_timer: the saturating idle counter with clear/inc and an expired output, parameterised by TIMEOUT.
- The packer FSM and lane registers stay in fifo_rd_packer.

Test Plan:
- Reset: rst=0 for 3 cycles with empty=0, outReady=1 -> rEn=0, outValid=0, outData=0, outCount=0 in every cycle; the FIFO read pointer is unchanged.
- Full beat: FIFO preloaded with 0x01,0x02,0x03,0x04, outReady=1 -> rEn=1 for 4 cycles; outValid=1 on the next cycle with outData=20'h20C41, outCount=4; accepted in 1 cycle.
- Backpressure: a full beat is pending and outReady=0 for 10 cycles while the FIFO is non-empty -> rEn=0 and outData stays stable throughout; when outReady=1 for one cycle the beat is accepted and rEn=1 on the following cycle.
- Timeout: 0x1F then 0x0A popped, then empty=1 held -> outValid rises exactly 15 posedges after the second pop, with outData=20'h0015F and outCount=2.
- Flush with simultaneous pop: idx=2 (lanes 0x03,0x05) and flush=1 in the same cycle as a pop of 0x07 -> next cycle outValid=1, outCount=3, outData=20'h01CA3.
- Reset mid-SEND: rst=0 for 1 cycle while outValid=1 and outReady=0 -> outValid=0 and outData=0 on the next cycle; the next beat starts at lane 0.
